// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 datapath: control-word field positions,
// ALU function codes and memory access sizes.
// Pure declarations; no ports, no latency, no flow control.
package legv8_pkg;

  // Control word field bit positions
  localparam int CW_MEM_OE    = 30;
  localparam int CW_B_EN      = 29;
  localparam int CW_SIZE_HI   = 28;
  localparam int CW_SIZE_LO   = 27;
  localparam int CW_ADDR_EN   = 26;
  localparam int CW_MEM_WRITE = 25;
  localparam int CW_ALU_EN    = 24;
  localparam int CW_MEM_CS    = 23;
  localparam int CW_C0        = 22;
  localparam int CW_FS_HI     = 21;
  localparam int CW_FS_LO     = 17;
  localparam int CW_BSEL      = 16;
  localparam int CW_REG_WRITE = 15;
  localparam int CW_SB_HI     = 14;
  localparam int CW_SB_LO     = 10;
  localparam int CW_SA_HI     = 9;
  localparam int CW_SA_LO     = 5;
  localparam int CW_DA_HI     = 4;
  localparam int CW_DA_LO     = 0;

  // FS[4:2] operation select; FS[1]/FS[0] invert the a/b operands
  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_ADD    = 3'b010,
    OP_XOR    = 3'b011,
    OP_LSL    = 3'b100,
    OP_LSR    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_PASS_B = 3'b111
  } alu_op_t;

  // Full FS codes for common operations (subtract needs C0 = 1)
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_t;

  // Number of bytes touched by an access of the given size (1, 2, 4, 8)
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/legv8_alu.sv
// 64-bit LEGv8 ALU: operand inversion, logic ops, adder, shifter and {V,C,N,Z}.
// Purely combinational; zero latency, no flow control.
// Ports: a_in/b_in operands, fs function select, c0 carry-in -> result, status.
module legv8_alu
  import legv8_pkg::*;
(
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  input  logic [4:0]  fs,
  input  logic        c0,
  output logic [63:0] result,
  output logic [3:0]  status
);

  logic [63:0] a;
  logic [63:0] b;
  logic [64:0] sum;
  logic        c_flag;
  logic        v_flag;
  alu_op_t     op;

  always_comb begin
    a      = fs[1] ? ~a_in : a_in;
    b      = fs[0] ? ~b_in : b_in;
    sum    = {1'b0, a} + {1'b0, b} + {64'd0, c0};
    op     = alu_op_t'(fs[4:2]);
    result = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_ADD: begin
        result = sum[63:0];
        c_flag = sum[64];
        // Signed overflow: like-signed operands producing an opposite-signed sum
        v_flag = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      OP_XOR:    result = a ^ b;
      OP_LSL:    result = a << b[5:0];
      OP_LSR:    result = a >> b[5:0];
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
      default:   result = '0;
    endcase
    status = {v_flag, c_flag, result[63], (result == 64'd0)};
  end

endmodule

// File: rtl/datapath_with_memory_legv8.sv
// LEGv8 datapath: 32x64 register file, ALU and byte-addressed RAM on a shared tri-state bus.
// Register/RAM writes take effect on the next rising clock; reads and status are combinational.
// No flow control: the external controller sequences one control word per cycle.
// Ports: clock/reset (sync, active-high), ControlWord, data (bus), address, constant,
//        status {V,C,N,Z}, r0..r7 (low 16 bits of R0..R7 for debug).
module datapath_with_memory_legv8
  import legv8_pkg::*;
#(
  parameter int RAM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ControlWord,
  inout  wire  [63:0] data,
  output logic [31:0] address,
  input  logic [63:0] constant,
  output logic [3:0]  status,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7
);

  // RAM_BYTES is expected to be a power of two so the address wraps naturally
  localparam int AW = $clog2(RAM_BYTES);

  // Control word decode
  logic       mem_oe, b_en, addr_en, mem_write, alu_en, mem_cs, c0, bsel, reg_write;
  logic [1:0] size;
  logic [4:0] fs, sb, sa, da;
  logic       unused_cw_reserved;

  assign mem_oe    = ControlWord[CW_MEM_OE];
  assign b_en      = ControlWord[CW_B_EN];
  assign size      = ControlWord[CW_SIZE_HI:CW_SIZE_LO];
  assign addr_en   = ControlWord[CW_ADDR_EN];
  assign mem_write = ControlWord[CW_MEM_WRITE];
  assign alu_en    = ControlWord[CW_ALU_EN];
  assign mem_cs    = ControlWord[CW_MEM_CS];
  assign c0        = ControlWord[CW_C0];
  assign fs        = ControlWord[CW_FS_HI:CW_FS_LO];
  assign bsel      = ControlWord[CW_BSEL];
  assign reg_write = ControlWord[CW_REG_WRITE];
  assign sb        = ControlWord[CW_SB_HI:CW_SB_LO];
  assign sa        = ControlWord[CW_SA_HI:CW_SA_LO];
  assign da        = ControlWord[CW_DA_HI:CW_DA_LO];
  assign unused_cw_reserved = ControlWord[31];

  // Register file; entry 31 exists only to keep indexing in range and is never visible
  logic [63:0] regs [32];
  logic [63:0] a_bus, b_bus, b_mux;

  assign a_bus = (sa == 5'd31) ? 64'd0 : regs[sa];
  assign b_bus = (sb == 5'd31) ? 64'd0 : regs[sb];
  assign b_mux = bsel ? constant : b_bus;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else if (reg_write && (da != 5'd31)) begin
      regs[da] <= data;
    end
  end

  // ALU
  logic [63:0] alu_result;

  legv8_alu u_alu (
    .a_in   (a_bus),
    .b_in   (b_mux),
    .fs     (fs),
    .c0     (c0),
    .result (alu_result),
    .status (status)
  );

  // Data RAM: little-endian, uninitialised, address wraps modulo RAM_BYTES
  logic [7:0]    mem [RAM_BYTES];
  logic [AW-1:0] base;
  logic [3:0]    nbytes;
  logic [63:0]   mem_rd;
  logic          mem_drive;

  assign base      = a_bus[AW-1:0];
  assign nbytes    = size_bytes(size);
  assign mem_drive = mem_cs && mem_oe && !mem_write;

  always_ff @(posedge clock) begin
    if (!reset && mem_cs && mem_write) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[AW'(base + AW'(i))] <= data[8*i +: 8];
      end
    end
  end

  // Zero-extended read: bytes beyond the access size stay 0
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) mem_rd[8*i +: 8] = mem[AW'(base + AW'(i))];
    end
  end

  // Bus drivers are mutually exclusive by contract, so the mux order carries no meaning
  assign data = alu_en    ? alu_result :
                b_en      ? b_bus      :
                mem_drive ? mem_rd     : {64{1'bz}};

  assign address = addr_en ? a_bus[31:0] : 32'd0;

  assign r0 = regs[0][15:0];
  assign r1 = regs[1][15:0];
  assign r2 = regs[2][15:0];
  assign r3 = regs[3][15:0];
  assign r4 = regs[4][15:0];
  assign r5 = regs[5][15:0];
  assign r6 = regs[6][15:0];
  assign r7 = regs[7][15:0];

endmodule

// File: tb/tb_datapath_with_memory_legv8.sv
module tb_datapath_with_memory_legv8;

  logic        clock;
  logic        reset;
  logic [31:0] ControlWord;
  wire  [63:0] data;
  logic [31:0] address;
  logic [63:0] constant;
  logic [3:0]  status;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] rv [8];

  int checks;
  int failures;

  datapath_with_memory_legv8 #(.RAM_BYTES(1024)) dut (
    .clock       (clock),
    .reset       (reset),
    .ControlWord (ControlWord),
    .data        (data),
    .address     (address),
    .constant    (constant),
    .status      (status),
    .r0 (r0), .r1 (r1), .r2 (r2), .r3 (r3),
    .r4 (r4), .r5 (r5), .r6 (r6), .r7 (r7)
  );

  assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
  assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Control word assembled from hand-listed field positions
  function automatic logic [31:0] mk(input logic mem_oe, input logic b_en, input logic [1:0] size,
                                     input logic addr_en, input logic mem_wr, input logic alu_en,
                                     input logic mem_cs, input logic c0, input logic [4:0] fs,
                                     input logic bsel, input logic reg_wr, input logic [4:0] sb,
                                     input logic [4:0] sa, input logic [4:0] da);
    return {1'b0, mem_oe, b_en, size, addr_en, mem_wr, alu_en, mem_cs, c0, fs, bsel, reg_wr, sb, sa, da};
  endfunction

  // ALU result written back to DA
  function automatic logic [31:0] alu_cw(input logic [4:0] fs, input logic c0, input logic bsel,
                                         input logic [4:0] sb, input logic [4:0] sa, input logic [4:0] da);
    return mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, c0, fs, bsel, 1'b1, sb, sa, da);
  endfunction

  // RAM[R[sa]] <= R[sb], size bytes
  function automatic logic [31:0] store_cw(input logic [1:0] size, input logic [4:0] sb, input logic [4:0] sa);
    return mk(1'b0, 1'b1, size, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, sb, sa, 5'd0);
  endfunction

  // R[da] <= RAM[R[sa]], size bytes, zero-extended
  function automatic logic [31:0] load_cw(input logic [1:0] size, input logic [4:0] sa, input logic [4:0] da);
    return mk(1'b1, 1'b0, size, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, sa, da);
  endfunction

  task automatic apply(input logic [31:0] w, input logic [63:0] k);
    ControlWord = w;
    constant    = k;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(32'd0, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rv[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_r%0d got=%h want=0000", i, rv[i]);
      end
    end
    checks++;
    if (address !== 32'd0) begin
      failures++;
      $display("FAIL reset_address got=%h want=00000000", address);
    end
  endtask

  task automatic test_alu_ops();
    // R0 <= R31 | 24
    apply(alu_cw(5'b00100, 1'b0, 1'b1, 5'd1, 5'd31, 5'd0), 64'd24);
    checks++;
    if (status !== 4'b0000) begin failures++; $display("FAIL or_status got=%b want=0000", status); end
    tick();
    checks++;
    if (r0 !== 16'h0018) begin failures++; $display("FAIL or_r0 got=%h want=0018", r0); end

    // R1 <= R31 - R0 = -24
    apply(alu_cw(5'b01001, 1'b1, 1'b0, 5'd0, 5'd31, 5'd1), 64'd0);
    checks++;
    if (status !== 4'b0010) begin failures++; $display("FAIL sub_status got=%b want=0010", status); end
    tick();
    checks++;
    if (r1 !== 16'hFFE8) begin failures++; $display("FAIL sub_r1 got=%h want=ffe8", r1); end

    // R6 <= R1 + 24 = 0, carry out
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd1, 5'd6), 64'd24);
    checks++;
    if (status !== 4'b0101) begin failures++; $display("FAIL carry_status got=%b want=0101", status); end
    tick();

    // R5 <= ~R31 >> 1 = 0x7FFF_FFFF_FFFF_FFFF
    apply(alu_cw(5'b10110, 1'b0, 1'b1, 5'd0, 5'd31, 5'd5), 64'd1);
    checks++;
    if (status !== 4'b0000) begin failures++; $display("FAIL lsr_status got=%b want=0000", status); end
    tick();
    checks++;
    if (r5 !== 16'hFFFF) begin failures++; $display("FAIL lsr_r5 got=%h want=ffff", r5); end

    // R6 <= R5 + 1 overflows to 0x8000_0000_0000_0000
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd5, 5'd6), 64'd1);
    checks++;
    if (status !== 4'b1010) begin failures++; $display("FAIL ovf_status got=%b want=1010", status); end
    tick();
    checks++;
    if (r6 !== 16'h0000) begin failures++; $display("FAIL ovf_r6 got=%h want=0000", r6); end

    // R4 <= R0 << 4
    apply(alu_cw(5'b10000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4), 64'd4);
    tick();
    checks++;
    if (r4 !== 16'h0180) begin failures++; $display("FAIL lsl_r4 got=%h want=0180", r4); end

    // R4 <= R0 ^ 0xFF
    apply(alu_cw(5'b01100, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4), 64'hFF);
    tick();
    checks++;
    if (r4 !== 16'h00E7) begin failures++; $display("FAIL xor_r4 got=%h want=00e7", r4); end

    // R4 <= pass constant
    apply(alu_cw(5'b11100, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4), 64'h1234);
    tick();
    checks++;
    if (r4 !== 16'h1234) begin failures++; $display("FAIL passb_r4 got=%h want=1234", r4); end
  endtask

  task automatic test_store();
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd31, 5'd7), 64'd24);
    tick();
    checks++;
    if (r7 !== 16'h0018) begin failures++; $display("FAIL store_r7 got=%h want=0018", r7); end
    apply(store_cw(2'b11, 5'd1, 5'd7), 64'd0);
    checks++;
    if (address !== 32'd24) begin failures++; $display("FAIL store_address got=%h want=00000018", address); end
    checks++;
    if (data !== 64'hFFFF_FFFF_FFFF_FFE8) begin
      failures++; $display("FAIL store_bus got=%h want=ffffffffffffffe8", data);
    end
    tick();
    // R1 <= R0 & R1
    apply(alu_cw(5'b00000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd1), 64'd0);
    checks++;
    if (address !== 32'd0) begin failures++; $display("FAIL noaddr_address got=%h want=00000000", address); end
    tick();
    checks++;
    if (r1 !== 16'h0008) begin failures++; $display("FAIL and_r1 got=%h want=0008", r1); end
  endtask

  task automatic test_load();
    apply(load_cw(2'b11, 5'd7, 5'd2), 64'd0);
    checks++;
    if (data !== 64'hFFFF_FFFF_FFFF_FFE8) begin
      failures++; $display("FAIL ld64_bus got=%h want=ffffffffffffffe8", data);
    end
    tick();
    checks++;
    if (r2 !== 16'hFFE8) begin failures++; $display("FAIL ld64_r2 got=%h want=ffe8", r2); end

    apply(load_cw(2'b00, 5'd7, 5'd3), 64'd0);
    checks++;
    if (data !== 64'h0000_0000_0000_00E8) begin
      failures++; $display("FAIL ld8_bus got=%h want=00000000000000e8", data);
    end
    tick();
    checks++;
    if (r3 !== 16'h00E8) begin failures++; $display("FAIL ld8_r3 got=%h want=00e8", r3); end

    apply(load_cw(2'b10, 5'd7, 5'd4), 64'd0);
    checks++;
    if (data !== 64'h0000_0000_FFFF_FFE8) begin
      failures++; $display("FAIL ld32_bus got=%h want=00000000ffffffe8", data);
    end
    tick();

    // R6 <= R7 + 1 = 25; byte and half from address 25
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd7, 5'd6), 64'd1);
    tick();
    apply(load_cw(2'b00, 5'd6, 5'd4), 64'd0);
    tick();
    checks++;
    if (r4 !== 16'h00FF) begin failures++; $display("FAIL ld8_off_r4 got=%h want=00ff", r4); end
    apply(load_cw(2'b01, 5'd6, 5'd5), 64'd0);
    checks++;
    if (data !== 64'h0000_0000_0000_FFFF) begin
      failures++; $display("FAIL ld16_bus got=%h want=000000000000ffff", data);
    end
    tick();
    checks++;
    if (r5 !== 16'hFFFF) begin failures++; $display("FAIL ld16_r5 got=%h want=ffff", r5); end
  endtask

  task automatic test_wrap();
    // Store R2 as a dword at 1020: bytes 1020..1023 then 0..3
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd31, 5'd7), 64'd1020);
    tick();
    apply(store_cw(2'b11, 5'd2, 5'd7), 64'd0);
    tick();
    apply(load_cw(2'b00, 5'd7, 5'd3), 64'd0);
    tick();
    checks++;
    if (r3 !== 16'h00E8) begin failures++; $display("FAIL wrap_lo_r3 got=%h want=00e8", r3); end
    apply(load_cw(2'b00, 5'd31, 5'd4), 64'd0);
    tick();
    checks++;
    if (r4 !== 16'h00FF) begin failures++; $display("FAIL wrap_hi_r4 got=%h want=00ff", r4); end
    apply(load_cw(2'b11, 5'd7, 5'd5), 64'd0);
    checks++;
    if (data !== 64'hFFFF_FFFF_FFFF_FFE8) begin
      failures++; $display("FAIL wrap_ld64_bus got=%h want=ffffffffffffffe8", data);
    end
    tick();
  endtask

  task automatic test_r31();
    apply(alu_cw(5'b00100, 1'b0, 1'b1, 5'd0, 5'd31, 5'd31), 64'd99);
    tick();
    apply(alu_cw(5'b00100, 1'b0, 1'b1, 5'd0, 5'd31, 5'd0), 64'd0);
    checks++;
    if (status !== 4'b0001) begin failures++; $display("FAIL r31_status got=%b want=0001", status); end
    tick();
    checks++;
    if (r0 !== 16'h0000) begin failures++; $display("FAIL r31_r0 got=%h want=0000", r0); end
  endtask

  task automatic test_reset_mid();
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd31, 5'd7), 64'd24);
    tick();
    // Store R1 (=8) at 24 and write R3 while reset is high: both must be blocked
    reset = 1'b1;
    apply(mk(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd7, 5'd3), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rv[i] !== 16'h0000) begin
        failures++;
        $display("FAIL midreset_r%0d got=%h want=0000", i, rv[i]);
      end
    end
    apply(alu_cw(5'b01000, 1'b0, 1'b1, 5'd0, 5'd31, 5'd7), 64'd24);
    tick();
    apply(load_cw(2'b11, 5'd7, 5'd2), 64'd0);
    checks++;
    if (data !== 64'hFFFF_FFFF_FFFF_FFE8) begin
      failures++; $display("FAIL retain_bus got=%h want=ffffffffffffffe8", data);
    end
    tick();
    checks++;
    if (r2 !== 16'hFFE8) begin failures++; $display("FAIL retain_r2 got=%h want=ffe8", r2); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    apply(alu_cw(5'b00100, 1'b0, 1'b1, 5'd0, 5'd31, 5'd0), 64'd1);
    tick();
    want = 16'd1;
    for (int i = 0; i < 4; i++) begin
      apply(alu_cw(5'b01000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0), 64'd0);
      tick();
      want = want << 1;
      checks++;
      if (r0 !== want) begin failures++; $display("FAIL b2b_step%0d got=%h want=%h", i, r0, want); end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    ControlWord = 32'd0;
    constant    = 64'd0;
    test_reset();
    test_alu_ops();
    test_store();
    test_load();
    test_wrap();
    test_r31();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
